// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares the single-ported unified I/D memory of the multicycle MIPS core
//   between the core and a debug/program-loader port. One transaction at a
//   time: grant (round-robin on ties), a fixed WAIT_CYCLES memory access,
//   then a one-cycle done pulse to the owner. Misaligned addresses skip the
//   memory and complete immediately with err set.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   c_* / d_*           core / debug request channels (req, we, addr, wdata
//                       in; rdata, done, err out)
//   m_*                 memory macro interface (all outputs registered)
//   busy                high in ACCESS and DONE
//   owner               current or most recent grantee (0 core, 1 debug)
module mem_port_arbiter #(
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int WAIT_CYCLES = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          c_req,
  input  logic          c_we,
  input  logic [AW-1:0] c_addr,
  input  logic [DW-1:0] c_wdata,
  output logic [DW-1:0] c_rdata,
  output logic          c_done,
  output logic          c_err,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_done,
  output logic          d_err,
  output logic          m_en,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata,
  output logic          busy,
  output logic          owner
);

  localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          last_grant;

  // Grant decision and selected fields. These feed registers only, so no
  // combinational path exists from any req to the m_* outputs.
  logic          any_req;
  logic          pick;
  logic          g_we;
  logic [AW-1:0] g_addr;
  logic [DW-1:0] g_wdata;

  always_comb begin
    any_req = c_req | d_req;
    pick    = (c_req && d_req) ? ~last_grant : d_req;
    g_we    = pick ? d_we    : c_we;
    g_addr  = pick ? d_addr  : c_addr;
    g_wdata = pick ? d_wdata : c_wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      last_grant <= 1'b1;   // core wins the first tie
      owner      <= 1'b0;
      busy       <= 1'b0;
      m_en       <= 1'b0;
      m_we       <= 1'b0;
      m_addr     <= '0;
      m_wdata    <= '0;
      c_rdata    <= '0;
      d_rdata    <= '0;
      c_done     <= 1'b0;
      d_done     <= 1'b0;
      c_err      <= 1'b0;
      d_err      <= 1'b0;
    end else begin
      // done/err are single-cycle pulses
      c_done <= 1'b0;
      d_done <= 1'b0;
      c_err  <= 1'b0;
      d_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            owner      <= pick;
            last_grant <= pick;
            busy       <= 1'b1;
            if (g_addr[1:0] != 2'b00) begin
              // misaligned: no memory access, report straight away
              state <= DONE;
              if (pick) begin
                d_done <= 1'b1;
                d_err  <= 1'b1;
              end else begin
                c_done <= 1'b1;
                c_err  <= 1'b1;
              end
            end else begin
              state   <= ACCESS;
              cnt     <= '0;
              m_en    <= 1'b1;
              m_we    <= g_we;
              m_addr  <= g_addr;
              m_wdata <= g_wdata;
            end
          end
        end
        ACCESS: begin
          if (cnt == CW'(WAIT_CYCLES - 1)) begin
            state <= DONE;
            m_en  <= 1'b0;
            m_we  <= 1'b0;
            if (owner) begin
              d_done <= 1'b1;
              if (!m_we) d_rdata <= m_rdata;
            end else begin
              c_done <= 1'b1;
              if (!m_we) c_rdata <= m_rdata;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int W  = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          rq_req [2];
  logic          rq_we  [2];
  logic [31:0]   rq_addr[2];
  logic [31:0]   rq_wdata[2];

  logic [DW-1:0] c_rdata, d_rdata, m_wdata, m_rdata;
  logic [AW-1:0] m_addr;
  logic          c_done, c_err, d_done, d_err, m_en, m_we, busy, owner;

  mem_port_arbiter #(.AW(AW), .DW(DW), .WAIT_CYCLES(W)) dut (
    .clk(clk), .rst(rst),
    .c_req(rq_req[0]), .c_we(rq_we[0]), .c_addr(rq_addr[0]), .c_wdata(rq_wdata[0]),
    .c_rdata(c_rdata), .c_done(c_done), .c_err(c_err),
    .d_req(rq_req[1]), .d_we(rq_we[1]), .d_addr(rq_addr[1]), .d_wdata(rq_wdata[1]),
    .d_rdata(d_rdata), .d_done(d_done), .d_err(d_err),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata),
    .busy(busy), .owner(owner)
  );

  // Memory fixture: 64 words, asynchronous read, write on clock edge.
  logic [31:0] fmem [64];
  logic        rd_ovr;
  logic [31:0] rd_val;
  assign m_rdata = rd_ovr ? rd_val : fmem[m_addr[7:2]];

  function automatic logic [31:0] init_word(input int i);
    return 32'h5A00_0000 ^ (32'(i) * 32'h0103_0507);
  endfunction

  always @(posedge clk) begin
    if (rst) for (int i = 0; i < 64; i++) fmem[i] <= init_word(i);
    else if (m_en && m_we) fmem[m_addr[7:2]] <= m_wdata;
  end

  // Transaction-level reference model state
  logic [31:0] mm [64];
  logic [31:0] exp_rd [2];
  logic        last_g, own;
  int          act, act_owner, act_g, act_done, act_mis, act_we, next_free;
  logic [31:0] act_addr, act_wd, act_rd;

  int checks = 0;
  int errors = 0;

  task automatic do_reset();
    rst = 1'b1;
    rd_ovr = 1'b0;
    rd_val = '0;
    for (int r = 0; r < 2; r++) begin
      rq_req[r] = 1'b0; rq_we[r] = 1'b0; rq_addr[r] = '0; rq_wdata[r] = '0;
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 64; i++) mm[i] = init_word(i);
    exp_rd[0] = '0; exp_rd[1] = '0;
    last_g = 1'b1; own = 1'b0;
    act = 0; next_free = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if ({c_done, d_done, c_err, d_err} !== 4'b0) begin errors++; $display("FAIL reset_flags got %b exp 0000", {c_done, d_done, c_err, d_err}); end
    checks++; if ({m_en, m_we, busy, owner} !== 4'b0) begin errors++; $display("FAIL reset_ctl got %b exp 0000", {m_en, m_we, busy, owner}); end
    checks++; if (c_rdata !== 32'h0 || d_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h/%h exp 0/0", c_rdata, d_rdata); end
    checks++; if (m_addr !== 32'h0 || m_wdata !== 32'h0) begin errors++; $display("FAIL reset_maddr got %h/%h exp 0/0", m_addr, m_wdata); end
    @(negedge clk);
    checks++; if (busy !== 1'b0 || m_en !== 1'b0) begin errors++; $display("FAIL reset_idle busy=%b m_en=%b exp 0/0", busy, m_en); end
  endtask

  task automatic test_core_read();
    do_reset();
    rd_ovr = 1'b1; rd_val = 32'hDEAD_BEEF;
    rq_req[0] = 1'b1; rq_we[0] = 1'b0; rq_addr[0] = 32'h10;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k <= 2) begin
        checks++; if ({m_en, m_we} !== 2'b10 || m_addr !== 32'h10) begin errors++; $display("FAIL core_read_access cyc %0d got en/we=%b addr=%h exp 10/00000010", k, {m_en, m_we}, m_addr); end
      end
      if (k == 3) begin
        checks++; if (c_done !== 1'b1 || c_err !== 1'b0) begin errors++; $display("FAIL core_read_done got done=%b err=%b exp 1/0", c_done, c_err); end
        checks++; if (c_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL core_read_data got %h exp deadbeef", c_rdata); end
        checks++; if (m_en !== 1'b0) begin errors++; $display("FAIL core_read_men_done got %b exp 0", m_en); end
        rq_req[0] = 1'b0;
      end else begin
        checks++; if (c_done !== 1'b0) begin errors++; $display("FAIL core_read_nodone cyc %0d got %b exp 0", k, c_done); end
      end
      checks++; if (d_done !== 1'b0) begin errors++; $display("FAIL core_read_ddone cyc %0d got %b exp 0", k, d_done); end
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL core_read_busy got %b exp 0", busy); end
    rd_ovr = 1'b0;
  endtask

  task automatic test_misaligned();
    do_reset();
    rd_ovr = 1'b1; rd_val = 32'hCAFE_F00D;
    rq_req[0] = 1'b1; rq_we[0] = 1'b0; rq_addr[0] = 32'h13;
    @(negedge clk);
    checks++; if (c_done !== 1'b1 || c_err !== 1'b1) begin errors++; $display("FAIL misalign_done got done=%b err=%b exp 1/1", c_done, c_err); end
    checks++; if (m_en !== 1'b0) begin errors++; $display("FAIL misalign_men got %b exp 0", m_en); end
    checks++; if (c_rdata !== 32'h0) begin errors++; $display("FAIL misalign_rdata got %h exp 0", c_rdata); end
    rq_req[0] = 1'b0;
    @(negedge clk);
    checks++; if (c_done !== 1'b0 || busy !== 1'b0 || m_en !== 1'b0) begin errors++; $display("FAIL misalign_after got done=%b busy=%b en=%b exp 000", c_done, busy, m_en); end
    rd_ovr = 1'b0;
  endtask

  task automatic test_reset_mid_access();
    do_reset();
    rq_req[0] = 1'b1; rq_we[0] = 1'b0; rq_addr[0] = 32'h8;
    @(negedge clk);
    @(negedge clk);
    checks++; if (m_en !== 1'b1) begin errors++; $display("FAIL rstmid_access got m_en=%b exp 1", m_en); end
    rst = 1'b1; rq_req[0] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    checks++; if ({m_en, m_we, busy, c_done} !== 4'b0) begin errors++; $display("FAIL rstmid_after got en/we/busy/done=%b exp 0000", {m_en, m_we, busy, c_done}); end
    @(negedge clk);
    checks++; if (c_done !== 1'b0 || d_done !== 1'b0) begin errors++; $display("FAIL rstmid_nodone got %b%b exp 00", c_done, d_done); end
    rq_req[0] = 1'b1; rq_addr[0] = 32'h4;
    rq_req[1] = 1'b1; rq_we[1] = 1'b0; rq_addr[1] = 32'h8;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (k == 1) begin
        checks++; if (owner !== 1'b0 || m_addr !== 32'h4) begin errors++; $display("FAIL rstmid_grant got owner=%b addr=%h exp 0/00000004", owner, m_addr); end
      end
      if (k == 3) begin
        checks++; if (c_done !== 1'b1 || d_done !== 1'b0) begin errors++; $display("FAIL rstmid_cdone got c=%b d=%b exp 1/0", c_done, d_done); end
        rq_req[0] = 1'b0;
      end
      if (k == 5) begin
        checks++; if (owner !== 1'b1 || m_addr !== 32'h8) begin errors++; $display("FAIL rstmid_grant2 got owner=%b addr=%h exp 1/00000008", owner, m_addr); end
      end
      if (k == 7) begin
        checks++; if (d_done !== 1'b1) begin errors++; $display("FAIL rstmid_ddone got %b exp 1", d_done); end
        rq_req[1] = 1'b0;
      end
    end
  endtask

  // Random traffic from both requesters against the transaction model.
  task automatic test_random(input int ntx, input int pct, input string name);
    int k, issued, finished, w, budget;
    bit dn, men;
    k = 0; issued = 0; finished = 0; budget = ntx * 30 + 200;
    do_reset();
    while (issued < ntx || finished < issued) begin
      if (k > budget) begin
        errors++;
        $display("FAIL %s timeout at cyc %0d finished %0d of %0d", name, k, finished, issued);
        break;
      end
      dn  = (act != 0) && (k == act_done);
      men = (act != 0) && (act_mis == 0) && (k > act_g) && (k <= act_g + W);
      if (dn && act_we == 0 && act_mis == 0) exp_rd[act_owner] = act_rd;
      checks++; if (c_done !== (dn && act_owner == 0)) begin errors++; $display("FAIL %s c_done cyc %0d got %b exp %b", name, k, c_done, dn && act_owner == 0); end
      checks++; if (d_done !== (dn && act_owner == 1)) begin errors++; $display("FAIL %s d_done cyc %0d got %b exp %b", name, k, d_done, dn && act_owner == 1); end
      if (dn) begin
        checks++; if ((act_owner == 1 ? d_err : c_err) !== (act_mis != 0)) begin errors++; $display("FAIL %s err cyc %0d got %b exp %b", name, k, act_owner == 1 ? d_err : c_err, act_mis != 0); end
      end
      checks++; if (m_en !== men) begin errors++; $display("FAIL %s m_en cyc %0d got %b exp %b", name, k, m_en, men); end
      if (men) begin
        checks++; if (m_we !== (act_we != 0) || m_addr !== act_addr) begin errors++; $display("FAIL %s m_we/addr cyc %0d got %b/%h exp %b/%h", name, k, m_we, m_addr, act_we != 0, act_addr); end
        if (act_we != 0) begin
          checks++; if (m_wdata !== act_wd) begin errors++; $display("FAIL %s m_wdata cyc %0d got %h exp %h", name, k, m_wdata, act_wd); end
        end
      end else begin
        checks++; if (m_we !== 1'b0) begin errors++; $display("FAIL %s m_we_idle cyc %0d got %b exp 0", name, k, m_we); end
      end
      checks++; if (busy !== ((act != 0) && k > act_g)) begin errors++; $display("FAIL %s busy cyc %0d got %b exp %b", name, k, busy, (act != 0) && k > act_g); end
      checks++; if (owner !== own) begin errors++; $display("FAIL %s owner cyc %0d got %b exp %b", name, k, owner, own); end
      checks++; if (c_rdata !== exp_rd[0] || d_rdata !== exp_rd[1]) begin errors++; $display("FAIL %s rdata cyc %0d got %h/%h exp %h/%h", name, k, c_rdata, d_rdata, exp_rd[0], exp_rd[1]); end

      if (dn) begin
        act = 0; finished++; rq_req[act_owner] = 1'b0;
      end
      for (int r = 0; r < 2; r++) begin
        int idx;
        if (!rq_req[r] && issued < ntx && $urandom_range(99) < pct) begin
          idx = $urandom_range(63);
          rq_we[r]    = 1'($urandom_range(1));
          rq_addr[r]  = 32'(idx) << 2;
          if ($urandom_range(7) == 0) rq_addr[r][1:0] = 2'($urandom_range(3, 1));
          rq_wdata[r] = $urandom;
          rq_req[r]   = 1'b1;
          issued++;
        end
      end
      if (act == 0 && k >= next_free && (rq_req[0] || rq_req[1])) begin
        w = (rq_req[0] && rq_req[1]) ? (last_g ? 0 : 1) : (rq_req[1] ? 1 : 0);
        last_g = w[0]; own = w[0];
        act = 1; act_owner = w; act_g = k;
        act_we = int'(rq_we[w]); act_addr = rq_addr[w]; act_wd = rq_wdata[w];
        act_mis = (act_addr[1:0] != 2'b00) ? 1 : 0;
        if (act_mis == 0) begin
          if (act_we != 0) mm[act_addr[7:2]] = act_wd;
          else act_rd = mm[act_addr[7:2]];
        end
        act_done = k + ((act_mis != 0) ? 1 : W + 1);
        next_free = act_done + 1;
      end
      @(negedge clk);
      k++;
    end
    rq_req[0] = 1'b0; rq_req[1] = 1'b0;
  endtask

  initial begin
    test_reset();
    test_core_read();
    test_misaligned();
    test_reset_mid_access();
    test_random(80, 40, "rand_mix");
    test_random(40, 100, "rand_both");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
